// File: rtl/alu_ctrl_sequencer.sv
// -----------------------------------------------------------------------------
// alu_ctrl_sequencer
//
// Control stage that sits in front of the regfile/ALU/RAM datapath. It accepts
// one micro-op at a time over a valid/ready handshake. It then drives the
// datapath control inputs with exact cycle timing, captures the datapath status
// flags at commit, and signals completion back to the issuing sequencer.
//
// Optional feature macro: COND_EXEC_EN
//   defined   : op 11 (COND) runs like an ALU op. Its RAM write is gated by
//               the Z flag (status[0]) at commit.
//   undefined : op 11 is unsupported. It behaves like a NOP and pulses uop_err
//               together with done.
//
// Ports
//   clock       in   1       rising-edge clock
//   reset       in   1       asynchronous, active-low reset
//   uop_valid   in   1       micro-op present
//   uop_ready   out  1       high only while idle
//   uop         in   UOP_W   {wram, msel, cin, fs, rb, ra, rd, op}
//   uop_imm     in   DATA_W  immediate for LOADI
//   status      in   4       datapath flags, status[0] = Z
//   write       out  1       regfile write enable
//   writeReg    out  REG_AW  regfile write address
//   data        out  DATA_W  regfile write data
//   readA/readB out  REG_AW  regfile read addresses
//   sel         out  SEL_W   ALU function select
//   muxSel      out  1       ALU A-side mux select
//   cin         out  1       ALU carry-in
//   writeRam    out  1       RAM write enable (single-cycle pulse)
//   status_q    out  4       status captured at commit
//   done        out  1       single-cycle completion pulse
//   uop_err     out  1       pulses with done for an unsupported op
// -----------------------------------------------------------------------------
module alu_ctrl_sequencer #(
    parameter int DATA_W      = 64,
    parameter int REG_AW      = 5,
    parameter int SEL_W       = 5,
    parameter int EXEC_CYCLES = 1,
    parameter int UOP_W       = 25
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              uop_valid,
    output logic              uop_ready,
    input  logic [UOP_W-1:0]  uop,
    input  logic [DATA_W-1:0] uop_imm,
    input  logic [3:0]        status,
    output logic              write,
    output logic [REG_AW-1:0] writeReg,
    output logic [DATA_W-1:0] data,
    output logic [REG_AW-1:0] readA,
    output logic [REG_AW-1:0] readB,
    output logic [SEL_W-1:0]  sel,
    output logic              muxSel,
    output logic              cin,
    output logic              writeRam,
    output logic [3:0]        status_q,
    output logic              done,
    output logic              uop_err
);

    // Field positions inside the micro-op word
    localparam int RD_LSB   = 2;
    localparam int RA_LSB   = RD_LSB + REG_AW;
    localparam int RB_LSB   = RA_LSB + REG_AW;
    localparam int FS_LSB   = RB_LSB + REG_AW;
    localparam int CIN_BIT  = FS_LSB + SEL_W;
    localparam int MSEL_BIT = CIN_BIT + 1;
    localparam int WRAM_BIT = CIN_BIT + 2;

    localparam logic [1:0] OP_LOADI = 2'b00;
    localparam logic [1:0] OP_ALU   = 2'b01;
    localparam logic [1:0] OP_NOP   = 2'b10;
    localparam logic [1:0] OP_COND  = 2'b11;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ISSUE  = 3'd1;
    localparam logic [2:0] ST_HOLD   = 3'd2;
    localparam logic [2:0] ST_COMMIT = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    // The counter holds the number of remaining HOLD cycles after ISSUE
    localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

    if ((EXEC_CYCLES < 1) || (EXEC_CYCLES > 15)) begin : g_bad_exec_cycles
        $error("alu_ctrl_sequencer: EXEC_CYCLES must be within 1..15");
    end

    // True for ops that drive the ALU and pass through COMMIT
    function automatic logic op_exec(input logic [1:0] op);
`ifdef COND_EXEC_EN
        return (op == OP_ALU) || (op == OP_COND);
`else
        return (op == OP_ALU);
`endif
    endfunction

    // True for ops this build cannot execute
    function automatic logic op_unsupported(input logic [1:0] op);
`ifdef COND_EXEC_EN
        return (op != op) ;
`else
        return (op == OP_COND);
`endif
    endfunction

    logic [2:0]        state_r;
    logic [2:0]        state_s;
    logic [3:0]        cnt_r;
    logic [3:0]        cnt_s;
    logic              accept_s;
    logic              mem_en_s;
    logic [1:0]        op_r;
    logic              wram_r;
    logic [1:0]        in_op_s;

    logic              write_r;
    logic [REG_AW-1:0] write_reg_r;
    logic [DATA_W-1:0] data_r;
    logic [REG_AW-1:0] read_a_r;
    logic [REG_AW-1:0] read_b_r;
    logic [SEL_W-1:0]  sel_r;
    logic              mux_sel_r;
    logic              cin_r;
    logic              write_ram_r;
    logic [3:0]        status_q_r;
    logic              done_r;
    logic              uop_err_r;

    assign in_op_s = uop[1:0];

    // Next-state and counter logic for the op sequencing FSM
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        accept_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (uop_valid) begin
                    state_s  = ST_ISSUE;
                    cnt_s    = CNT_INIT;
                    accept_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (op_exec(op_r)) begin
                    if (cnt_r == 4'd0) begin
                        state_s = ST_COMMIT;
                    end else begin
                        state_s = ST_HOLD;
                        cnt_s   = cnt_r - 4'd1;
                    end
                end else begin
                    // LOADI, NOP and unsupported ops finish straight away
                    state_s = ST_DONE;
                end
            end
            ST_HOLD: begin
                if (cnt_r == 4'd0) begin
                    state_s = ST_COMMIT;
                end else begin
                    state_s = ST_HOLD;
                    cnt_s   = cnt_r - 4'd1;
                end
            end
            ST_COMMIT: state_s = ST_DONE;
            ST_DONE:   state_s = ST_IDLE;
            default: begin
                state_s = ST_IDLE;
                cnt_s   = 4'd0;
            end
        endcase
    end

    // RAM write qualifier; a conditional op only writes when Z is set
    always_comb begin
        if (op_r == OP_COND) begin
            mem_en_s = wram_r & status[0];
        end else begin
            mem_en_s = wram_r;
        end
    end

    // FSM state, counter and the latched op attributes
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            op_r    <= OP_NOP;
            wram_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            if (accept_s) begin
                op_r   <= in_op_s;
                wram_r <= uop[WRAM_BIT];
            end else begin
                op_r   <= op_r;
                wram_r <= wram_r;
            end
        end
    end

    // Regfile write port: pulse during ISSUE; address and data persist afterwards
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            write_r     <= 1'b0;
            write_reg_r <= '0;
            data_r      <= '0;
        end else begin
            write_r <= accept_s && (in_op_s == OP_LOADI);
            if (accept_s && (in_op_s == OP_LOADI)) begin
                write_reg_r <= uop[RD_LSB +: REG_AW];
                data_r      <= uop_imm;
            end else begin
                write_reg_r <= write_reg_r;
                data_r      <= data_r;
            end
        end
    end

    // ALU controls: loaded at accept and held until the next ALU-type op
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            read_a_r  <= '0;
            read_b_r  <= '0;
            sel_r     <= '0;
            cin_r     <= 1'b0;
            mux_sel_r <= 1'b0;
        end else if (accept_s && op_exec(in_op_s)) begin
            read_a_r  <= uop[RA_LSB +: REG_AW];
            read_b_r  <= uop[RB_LSB +: REG_AW];
            sel_r     <= uop[FS_LSB +: SEL_W];
            cin_r     <= uop[CIN_BIT];
            mux_sel_r <= uop[MSEL_BIT];
        end else begin
            read_a_r  <= read_a_r;
            read_b_r  <= read_b_r;
            sel_r     <= sel_r;
            cin_r     <= cin_r;
            mux_sel_r <= mux_sel_r;
        end
    end

    // Commit-side outputs: RAM pulse, status capture, completion and error pulses
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            write_ram_r <= 1'b0;
            status_q_r  <= 4'd0;
            done_r      <= 1'b0;
            uop_err_r   <= 1'b0;
        end else begin
            write_ram_r <= (state_s == ST_COMMIT) && mem_en_s;
            // Status is taken at the end of COMMIT, after the controls have settled
            if (state_r == ST_COMMIT) begin
                status_q_r <= status;
            end else begin
                status_q_r <= status_q_r;
            end
            done_r    <= (state_s == ST_DONE);
            uop_err_r <= (state_s == ST_DONE) && op_unsupported(op_r);
        end
    end

    assign uop_ready = (state_r == ST_IDLE);
    assign write     = write_r;
    assign writeReg  = write_reg_r;
    assign data      = data_r;
    assign readA     = read_a_r;
    assign readB     = read_b_r;
    assign sel       = sel_r;
    assign muxSel    = mux_sel_r;
    assign cin       = cin_r;
    assign writeRam  = write_ram_r;
    assign status_q  = status_q_r;
    assign done      = done_r;
    assign uop_err   = uop_err_r;

endmodule

// File: tb/tb_alu_ctrl_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for alu_ctrl_sequencer. It instantiates two copies of the design:
// instance 0 uses EXEC_CYCLES=1 and instance 1 uses EXEC_CYCLES=3. Each op is
// checked cycle by cycle against a timeline derived from the latency rules:
// writes relative to the accept edge, completion, ready, and retained controls.
// -----------------------------------------------------------------------------
module tb_alu_ctrl_sequencer;

`ifdef COND_EXEC_EN
    localparam bit COND_EN = 1'b1;
`else
    localparam bit COND_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        uop_valid_a [2];
    logic        uop_ready_a [2];
    logic [24:0] uop_a       [2];
    logic [63:0] imm_a       [2];
    logic [3:0]  status_a    [2];
    logic        write_a     [2];
    logic [4:0]  writeReg_a  [2];
    logic [63:0] data_a      [2];
    logic [4:0]  readA_a     [2];
    logic [4:0]  readB_a     [2];
    logic [4:0]  sel_a       [2];
    logic        muxSel_a    [2];
    logic        cin_a       [2];
    logic        writeRam_a  [2];
    logic [3:0]  status_q_a  [2];
    logic        done_a      [2];
    logic        uop_err_a   [2];

    // reference state: what each instance should currently be presenting
    logic [4:0]  m_ra [2];
    logic [4:0]  m_rb [2];
    logic [4:0]  m_fs [2];
    logic        m_cin [2];
    logic        m_msel [2];
    logic [4:0]  m_wreg [2];
    logic [63:0] m_data [2];
    logic [3:0]  m_sq [2];
    logic [63:0] regs [32];

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clock = ~clock;

    alu_ctrl_sequencer #(.EXEC_CYCLES(1)) dut0 (
        .clock(clock), .reset(reset),
        .uop_valid(uop_valid_a[0]), .uop_ready(uop_ready_a[0]),
        .uop(uop_a[0]), .uop_imm(imm_a[0]), .status(status_a[0]),
        .write(write_a[0]), .writeReg(writeReg_a[0]), .data(data_a[0]),
        .readA(readA_a[0]), .readB(readB_a[0]), .sel(sel_a[0]),
        .muxSel(muxSel_a[0]), .cin(cin_a[0]), .writeRam(writeRam_a[0]),
        .status_q(status_q_a[0]), .done(done_a[0]), .uop_err(uop_err_a[0])
    );

    alu_ctrl_sequencer #(.EXEC_CYCLES(3)) dut1 (
        .clock(clock), .reset(reset),
        .uop_valid(uop_valid_a[1]), .uop_ready(uop_ready_a[1]),
        .uop(uop_a[1]), .uop_imm(imm_a[1]), .status(status_a[1]),
        .write(write_a[1]), .writeReg(writeReg_a[1]), .data(data_a[1]),
        .readA(readA_a[1]), .readB(readB_a[1]), .sel(sel_a[1]),
        .muxSel(muxSel_a[1]), .cin(cin_a[1]), .writeRam(writeRam_a[1]),
        .status_q(status_q_a[1]), .done(done_a[1]), .uop_err(uop_err_a[1])
    );

    function automatic int ex_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    // Z flag of a toy datapath: add, subtract, otherwise xor
    function automatic logic alu_z(input logic [4:0] fs, input logic [63:0] a,
                                   input logic [63:0] b, input logic c);
        logic [63:0] r;
        if (fs == 5'b10000)      r = a + b + {63'd0, c};
        else if (fs == 5'b10010) r = a + ~b + {63'd0, c};
        else                     r = a ^ b;
        return (r == 64'd0);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            m_ra[i] = 5'd0; m_rb[i] = 5'd0; m_fs[i] = 5'd0;
            m_cin[i] = 1'b0; m_msel[i] = 1'b0;
            m_wreg[i] = 5'd0; m_data[i] = 64'd0; m_sq[i] = 4'd0;
        end
    endtask

    // Issue one op on instance i and follow it until the instance is idle again
    task automatic exercise_op(input int i, input logic [1:0] op, input logic [4:0] rd,
                               input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] fs,
                               input logic c, input logic ms, input logic wr,
                               input logic [63:0] imm, input logic [3:0] st);
        int  e;
        int  last;
        bit  exec;
        bit  mem;
        bit  err;
        e    = ex_of(i);
        exec = (op == 2'b01) || ((op == 2'b11) && COND_EN);
        mem  = exec && wr && ((op != 2'b11) || st[0]);
        err  = (op == 2'b11) && !COND_EN;
        last = exec ? e + 2 : 2;
        n_chk++;
        if (uop_ready_a[i] !== 1'b1) $display("FAIL ready_before_issue inst%0d got %b want 1", i, uop_ready_a[i]);
        else n_pass++;
        uop_a[i]       = {wr, ms, c, fs, rb, ra, rd, op};
        imm_a[i]       = imm;
        status_a[i]    = st;
        uop_valid_a[i] = 1'b1;
        @(posedge clock);
        #1;
        uop_valid_a[i] = 1'b0;
        if (op == 2'b00) begin
            m_wreg[i] = rd; m_data[i] = imm;
        end
        if (exec) begin
            m_ra[i] = ra; m_rb[i] = rb; m_fs[i] = fs; m_cin[i] = c; m_msel[i] = ms;
        end
        for (int t = 0; t <= last; t++) begin
            logic [3:0] exp_sq;
            exp_sq = (exec && (t >= e + 1)) ? st : m_sq[i];
            n_chk++;
            if (write_a[i] !== ((op == 2'b00) && (t == 0)))
                $display("FAIL write inst%0d op%0d t=%0d got %b", i, op, t, write_a[i]);
            else n_pass++;
            n_chk++;
            if (writeRam_a[i] !== (mem && (t == e)))
                $display("FAIL writeRam inst%0d op%0d t=%0d got %b", i, op, t, writeRam_a[i]);
            else n_pass++;
            n_chk++;
            if (done_a[i] !== (t == (exec ? e + 1 : 1)))
                $display("FAIL done inst%0d op%0d t=%0d got %b", i, op, t, done_a[i]);
            else n_pass++;
            n_chk++;
            if (uop_err_a[i] !== (err && (t == 1)))
                $display("FAIL uop_err inst%0d op%0d t=%0d got %b", i, op, t, uop_err_a[i]);
            else n_pass++;
            n_chk++;
            if (uop_ready_a[i] !== (t == last))
                $display("FAIL uop_ready inst%0d op%0d t=%0d got %b", i, op, t, uop_ready_a[i]);
            else n_pass++;
            n_chk++;
            if (status_q_a[i] !== exp_sq)
                $display("FAIL status_q inst%0d op%0d t=%0d got %h want %h", i, op, t, status_q_a[i], exp_sq);
            else n_pass++;
            n_chk++;
            if ({readA_a[i], readB_a[i], sel_a[i], cin_a[i], muxSel_a[i]} !==
                {m_ra[i], m_rb[i], m_fs[i], m_cin[i], m_msel[i]})
                $display("FAIL alu_ctrl inst%0d op%0d t=%0d got %h want %h", i, op, t,
                         {readA_a[i], readB_a[i], sel_a[i], cin_a[i], muxSel_a[i]},
                         {m_ra[i], m_rb[i], m_fs[i], m_cin[i], m_msel[i]});
            else n_pass++;
            n_chk++;
            if ({writeReg_a[i], data_a[i]} !== {m_wreg[i], m_data[i]})
                $display("FAIL wr_port inst%0d op%0d t=%0d got %0d/%h want %0d/%h", i, op, t,
                         writeReg_a[i], data_a[i], m_wreg[i], m_data[i]);
            else n_pass++;
            if (t < last) begin
                @(posedge clock);
                #1;
            end
        end
        if (exec) m_sq[i] = st;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            n_chk++;
            if ({write_a[i], writeRam_a[i], done_a[i], uop_err_a[i], status_q_a[i]} !== 8'd0)
                $display("FAIL reset_pulses inst%0d got %b want 0", i,
                         {write_a[i], writeRam_a[i], done_a[i], uop_err_a[i], status_q_a[i]});
            else n_pass++;
            n_chk++;
            if ({readA_a[i], readB_a[i], sel_a[i], cin_a[i], muxSel_a[i], writeReg_a[i], data_a[i]} !== 86'd0)
                $display("FAIL reset_ctrl inst%0d not zero", i);
            else n_pass++;
            n_chk++;
            if (uop_ready_a[i] !== 1'b1) $display("FAIL reset_ready inst%0d got %b want 1", i, uop_ready_a[i]);
            else n_pass++;
        end
    endtask

    task automatic test_loadi();
        exercise_op(0, 2'b00, 5'd29, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 64'd14, 4'd0);
        exercise_op(0, 2'b00, 5'd30, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 64'd14, 4'd0);
        exercise_op(1, 2'b00, 5'd3, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 64'hDEAD_BEEF_0123_4567, 4'd0);
        regs[29] = 64'd14;
        regs[30] = 64'd14;
    endtask

    task automatic test_alu();
        logic z;
        z = alu_z(5'b10000, regs[30], regs[29], 1'b0);
        exercise_op(0, 2'b01, 5'd0, 5'd30, 5'd29, 5'b10000, 1'b0, 1'b0, 1'b1, 64'd0, {3'b000, z});
        z = alu_z(5'b10010, regs[30], regs[29], 1'b1);
        exercise_op(1, 2'b01, 5'd0, 5'd30, 5'd29, 5'b10010, 1'b1, 1'b1, 1'b1, 64'd0, {3'b010, z});
        exercise_op(0, 2'b10, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 64'd0, 4'hF);
    endtask

    task automatic test_cond();
        for (int i = 0; i < 2; i++) begin
            exercise_op(i, 2'b11, 5'd0, 5'd1, 5'd2, 5'd7, 1'b0, 1'b1, 1'b1, 64'd0, 4'b0000);
            exercise_op(i, 2'b11, 5'd0, 5'd4, 5'd5, 5'd9, 1'b1, 1'b0, 1'b1, 64'd0, 4'b1001);
        end
    endtask

    // uop_valid stays high while busy; the second op must be taken once, right after idle
    task automatic test_back_to_back();
        int         e;
        logic [63:0] bimm;
        e    = ex_of(0);
        bimm = {$urandom, $urandom};
        uop_a[0]       = {1'b1, 1'b0, 1'b1, 5'd6, 5'd2, 5'd1, 5'd0, 2'b01};
        status_a[0]    = 4'b0110;
        imm_a[0]       = 64'd0;
        uop_valid_a[0] = 1'b1;
        @(posedge clock);
        #1;
        uop_a[0] = {1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd7, 2'b00};
        imm_a[0] = bimm;
        for (int t = 0; t <= e + 5; t++) begin
            n_chk++;
            if (write_a[0] !== (t == e + 3)) $display("FAIL b2b_write t=%0d got %b", t, write_a[0]);
            else n_pass++;
            n_chk++;
            if (writeRam_a[0] !== (t == e)) $display("FAIL b2b_writeRam t=%0d got %b", t, writeRam_a[0]);
            else n_pass++;
            n_chk++;
            if (done_a[0] !== ((t == e + 1) || (t == e + 4))) $display("FAIL b2b_done t=%0d got %b", t, done_a[0]);
            else n_pass++;
            n_chk++;
            if (uop_ready_a[0] !== ((t == e + 2) || (t == e + 5)))
                $display("FAIL b2b_ready t=%0d got %b", t, uop_ready_a[0]);
            else n_pass++;
            if (t == e + 3) uop_valid_a[0] = 1'b0;
            if (t < e + 5) begin
                @(posedge clock);
                #1;
            end
        end
        n_chk++;
        if ({writeReg_a[0], data_a[0], status_q_a[0]} !== {5'd7, bimm, 4'b0110})
            $display("FAIL b2b_result got %0d/%h/%h want 7/%h/6", writeReg_a[0], data_a[0], status_q_a[0], bimm);
        else n_pass++;
        m_ra[0] = 5'd1; m_rb[0] = 5'd2; m_fs[0] = 5'd6; m_cin[0] = 1'b1; m_msel[0] = 1'b0;
        m_wreg[0] = 5'd7; m_data[0] = bimm; m_sq[0] = 4'b0110;
    endtask

    // Reset while both instances are mid-op: everything drops at once and nothing fires later
    task automatic test_reset_mid_op();
        for (int i = 0; i < 2; i++) begin
            uop_a[i]       = {1'b1, 1'b1, 1'b1, 5'd3, 5'd4, 5'd5, 5'd6, 2'b01};
            status_a[i]    = 4'b0101;
            uop_valid_a[i] = 1'b1;
        end
        @(posedge clock);
        #1;
        uop_valid_a[0] = 1'b0;
        uop_valid_a[1] = 1'b0;
        @(posedge clock);
        #1;
        n_chk++;
        if (writeRam_a[0] !== 1'b1) $display("FAIL mid_pre_writeRam got %b want 1", writeRam_a[0]);
        else n_pass++;
        #2;
        reset = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            n_chk++;
            if ({write_a[i], writeRam_a[i], done_a[i], uop_ready_a[i]} !== 4'b0001)
                $display("FAIL mid_reset inst%0d got %b want 0001", i,
                         {write_a[i], writeRam_a[i], done_a[i], uop_ready_a[i]});
            else n_pass++;
        end
        #2;
        reset = 1'b1;
        model_clear();
        for (int c = 0; c < 5; c++) begin
            @(posedge clock);
            #1;
            for (int i = 0; i < 2; i++) begin
                n_chk++;
                if ({writeRam_a[i], done_a[i], uop_ready_a[i], status_q_a[i]} !== 7'b0010000)
                    $display("FAIL post_reset inst%0d c=%0d got %b", i, c,
                             {writeRam_a[i], done_a[i], uop_ready_a[i], status_q_a[i]});
                else n_pass++;
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            int         i;
            logic [1:0] op;
            i  = int'($urandom_range(0, 1));
            op = 2'($urandom_range(0, 3));
            exercise_op(i, op, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                        1'($urandom), 1'($urandom), 1'($urandom), {$urandom, $urandom}, 4'($urandom));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            uop_valid_a[i] = 1'b0;
            uop_a[i]       = 25'd0;
            imm_a[i]       = 64'd0;
            status_a[i]    = 4'd0;
        end
        for (int r = 0; r < 32; r++) regs[r] = 64'd0;
        model_clear();
        #12;
        test_reset();
        #11;
        reset = 1'b1;
        @(posedge clock);
        #1;
        test_loadi();
        test_alu();
        test_cond();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
